// File: rtl/hr_pkg.sv
// Shared definitions for the data-memory responder and its heart-rate peripheral:
// MMIO register offsets, STATUS bit positions and counter sizing helpers.
package hr_pkg;

  localparam int IBI_W = 16;

  localparam logic [3:0] OFF_STATUS  = 4'd0;
  localparam logic [3:0] OFF_BEATCNT = 4'd1;
  localparam logic [3:0] OFF_IBI_LO  = 4'd2;
  localparam logic [3:0] OFF_IBI_HI  = 4'd3;
  localparam logic [3:0] OFF_LED     = 4'd4;

  localparam int ST_NEW     = 0;
  localparam int ST_TIMEOUT = 1;

  // Width able to index n states; never below one bit so degenerate dividers still elaborate.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/beat_detect.sv
// Sensor front end: synchronises the raw beat pulse, detects rising edges, runs the
// ms-tick prescaler and the refractory window, and flags accepted beats.
module beat_detect
  import hr_pkg::*;
#(
  parameter int TICK_DIV      = 1000,
  parameter int REFRACT_TICKS = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic beat_in,
  output logic tick,
  output logic accept
);

  localparam int PW = cnt_width(TICK_DIV);
  localparam int RW = cnt_width(REFRACT_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX    = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REFRACT_LOAD = RW'(REFRACT_TICKS);

  // sync_q[0..1] are the synchroniser stages, sync_q[2] holds the previous level for edge detect.
  logic [2:0]    sync_q, sync_d;
  logic          edge_q, edge_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [RW-1:0] refr_q, refr_d;

  assign tick   = (presc_q == PRESC_MAX);
  assign accept = edge_q && (refr_q == '0);

  always_comb begin
    sync_d = {sync_q[1:0], beat_in};
    edge_d = sync_q[1] & ~sync_q[2];

    // An accepted beat restarts the ms grid so the next interval is measured from the beat itself.
    if (accept || tick) presc_d = '0;
    else                presc_d = presc_q + 1'b1;

    refr_d = refr_q;
    if (accept)                      refr_d = REFRACT_LOAD;
    else if (tick && refr_q != '0)   refr_d = refr_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      presc_q <= '0;
      refr_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      presc_q <= presc_d;
      refr_q  <= refr_d;
    end
  end

endmodule

// File: rtl/dmem_hr_responder.sv
// CPU data-side responder: zero-latency RAM reads plus a polled heart-rate peripheral
// (STATUS, BEATCNT, IBI, LED) mapped into a 16-byte window.
module dmem_hr_responder
  import hr_pkg::*;
#(
  parameter int         RAM_DEPTH     = 64,
  parameter logic [7:0] MMIO_BASE     = 8'hF0,
  parameter int         TICK_DIV      = 1000,
  parameter int         REFRACT_TICKS = 250
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  input  logic       MW,
  output logic [7:0] RDATA,
  input  logic       BEAT_IN,
  output logic [7:0] LED,
  output logic       NEW_BEAT
);

  localparam int AW = cnt_width(RAM_DEPTH);

  logic             tick, accept;
  logic             ram_hit, mmio_hit;
  logic [3:0]       mmio_off;
  logic             wr_status, wr_beatcnt, wr_led;

  logic [7:0]       mem_q [RAM_DEPTH];
  logic [1:0]       status_q, status_d;
  logic [7:0]       beatcnt_q, beatcnt_d;
  logic [IBI_W-1:0] ibi_q, ibi_d;
  logic [IBI_W-1:0] interval_q, interval_d;
  logic [7:0]       led_q, led_d;

  beat_detect #(
    .TICK_DIV      (TICK_DIV),
    .REFRACT_TICKS (REFRACT_TICKS)
  ) u_beat_detect (
    .clk     (CLK),
    .rst_n   (RESET_L),
    .beat_in (BEAT_IN),
    .tick    (tick),
    .accept  (accept)
  );

  // The window is 16-byte aligned, so only the upper nibble identifies it.
  assign ram_hit    = (int'(ADDR) < RAM_DEPTH);
  assign mmio_hit   = (ADDR[7:4] == MMIO_BASE[7:4]);
  assign mmio_off   = ADDR[3:0];
  assign wr_status  = MW && mmio_hit && (mmio_off == OFF_STATUS);
  assign wr_beatcnt = MW && mmio_hit && (mmio_off == OFF_BEATCNT);
  assign wr_led     = MW && mmio_hit && (mmio_off == OFF_LED);

  for (genvar gi = 0; gi < RAM_DEPTH; gi++) begin : g_ram
    logic [7:0] word_d;
    assign word_d = (MW && ram_hit && ADDR == 8'(gi)) ? WDATA : mem_q[gi];
    always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) mem_q[gi] <= '0;
      else          mem_q[gi] <= word_d;
    end
  end

  always_comb begin
    // Clears are applied first so that a same-cycle event setting a flag wins over the W1C.
    status_d = status_q;
    if (wr_status) status_d = status_q & ~WDATA[1:0];
    if (tick && !accept && interval_q == {{(IBI_W-1){1'b1}}, 1'b0}) status_d[ST_TIMEOUT] = 1'b1;
    if (accept) status_d[ST_NEW] = 1'b1;

    beatcnt_d = beatcnt_q;
    if (wr_beatcnt) beatcnt_d = '0;
    if (accept)     beatcnt_d = beatcnt_d + 8'd1;

    ibi_d = accept ? interval_q : ibi_q;

    interval_d = interval_q;
    if (accept)                                      interval_d = '0;
    else if (tick && interval_q != {IBI_W{1'b1}})    interval_d = interval_q + 1'b1;

    led_d = wr_led ? WDATA : led_q;
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      status_q   <= '0;
      beatcnt_q  <= '0;
      ibi_q      <= '0;
      interval_q <= '0;
      led_q      <= '0;
    end else begin
      status_q   <= status_d;
      beatcnt_q  <= beatcnt_d;
      ibi_q      <= ibi_d;
      interval_q <= interval_d;
      led_q      <= led_d;
    end
  end

  always_comb begin
    RDATA = 8'h00;
    if (ram_hit) begin
      RDATA = mem_q[ADDR[AW-1:0]];
    end else if (mmio_hit) begin
      case (mmio_off)
        OFF_STATUS:  RDATA = {6'b0, status_q};
        OFF_BEATCNT: RDATA = beatcnt_q;
        OFF_IBI_LO:  RDATA = ibi_q[7:0];
        OFF_IBI_HI:  RDATA = ibi_q[15:8];
        OFF_LED:     RDATA = led_q;
        default:     RDATA = 8'h00;
      endcase
    end
  end

  assign LED      = led_q;
  assign NEW_BEAT = status_q[ST_NEW];

endmodule
